// File: rtl/dmem_responder.sv
// Word-addressed data-port store answering the Processor's valid/ready handshake.
// Ready pulses LATENCY edges after accept; one request in flight, new requests taken only in IDLE.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cache_addr_data,
  input  logic [31:0] cache_wr_data,
  input  logic        cache_rw_data,
  input  logic        cache_valid_data,
  input  logic        cache_flush_data,
  output logic [31:0] cache_rd_data,
  output logic        cache_ready_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] word;
    logic [31:0]       wdat;
    logic              rw;
    logic              flush;
  } req_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  req_t        req;
  logic        accept;
  logic        fire;
  logic        mem_we;
  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  // Byte-lane and aliasing bits carry no meaning for a word store.
  logic unused_addr;
  assign unused_addr = ^{cache_addr_data[31:ADDR_W+2], cache_addr_data[1:0]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (cache_valid_data) begin
          accept  = 1'b1;
          cnt_n   = CNT_LOAD;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          fire    = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign mem_we = fire && req.rw && !req.flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      req              <= '0;
      cache_rd_data    <= 32'h0;
      cache_ready_data <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      cache_ready_data <= (state_n == RESP);
      if (accept) begin
        req.word  <= cache_addr_data[ADDR_W+1:2];
        req.wdat  <= cache_wr_data;
        req.rw    <= cache_rw_data;
        req.flush <= cache_flush_data;
      end
      // Flush leaves the read register untouched; writes echo their data.
      if (fire && !req.flush) begin
        cache_rd_data <= req.rw ? req.wdat : mem[req.word];
      end
    end
  end

  // Store is deliberately outside the reset domain so contents survive RST.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[req.word] <= req.wdat;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder across four latencies, checked against an array model.
module tb_dmem_responder;

  localparam int NINST = 4;

  logic        clk = 1'b0;
  logic        rst_all = 1'b1;
  logic        rst_one = 1'b0;
  int          sel = 0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic        rw = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        ready_a [NINST];
  logic [31:0] rd_a [NINST];

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mdl [1024];
  logic [31:0] rd_exp = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : gen_dut
    dmem_responder #(
      .ADDR_W (10),
      .LATENCY(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 15)
    ) u_dut (
      .CLK             (clk),
      .RST             (rst_all | (rst_one && sel == g)),
      .cache_addr_data (addr),
      .cache_wr_data   (wdat),
      .cache_rw_data   (rw),
      .cache_valid_data(valid && sel == g),
      .cache_flush_data(flush),
      .cache_rd_data   (rd_a[g]),
      .cache_ready_data(ready_a[g])
    );
  end

  function automatic int lat_of(input int s);
    case (s)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 15;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  // Entered and left at a falling edge; the request is accepted at the next rising edge.
  task automatic req(input logic w, input logic f, input logic [31:0] a, input logic [31:0] d,
                     input bit wiggle, input bit hold);
    int L;
    logic [31:0] prev;
    L = lat_of(sel);
    prev = rd_exp;
    valid = 1'b1; rw = w; flush = f; addr = a; wdat = d;
    if (!f) begin
      if (w) begin
        mdl[widx(a)] = d;
        rd_exp = d;
      end else begin
        rd_exp = mdl[widx(a)];
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("ready_at_accept", {31'b0, ready_a[sel]}, 32'd0);
    check("rd_hold_at_accept", rd_a[sel], prev);
    if (!hold) valid = 1'b0;
    if (wiggle) begin
      addr = a + 32'h10;
      wdat = ~d;
      rw = ~w;
      flush = ~f;
    end
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      check("ready_pulse", {31'b0, ready_a[sel]}, (k == L) ? 32'd1 : 32'd0);
      check("rd_data", rd_a[sel], (k >= L) ? rd_exp : prev);
    end
  endtask

  task automatic reset_mid_write();
    valid = 1'b1; rw = 1'b1; flush = 1'b0; addr = 32'h10; wdat = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst_one = 1'b1;
    #1;
    check("rst_ready_now", {31'b0, ready_a[sel]}, 32'd0);
    check("rst_rd_now", rd_a[sel], 32'd0);
    rd_exp = 32'h0;
    @(negedge clk);
    check("rst_ready_held", {31'b0, ready_a[sel]}, 32'd0);
    check("rst_rd_held", rd_a[sel], 32'd0);
    rst_one = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    #1;
    for (int i = 0; i < NINST; i++) begin
      sel = i;
      check("reset_ready", {31'b0, ready_a[i]}, 32'd0);
      check("reset_rd", rd_a[i], 32'd0);
    end
    sel = 0;
    repeat (2) @(negedge clk);
    rst_all = 1'b0;

    for (int s = 0; s < NINST; s++) begin
      valid = 1'b0;
      sel = s;
      rd_exp = 32'h0;

      for (int w = 0; w < 32; w++) req(1'b1, 1'b0, 32'(w * 4), $urandom | 32'h1, 1'b0, 1'b0);

      req(1'b1, 1'b0, 32'h04, 32'h12345678, 1'b0, 1'b0);
      req(1'b0, 1'b0, 32'h04, 32'h0, 1'b0, 1'b0);
      check("sweep_rd", rd_a[sel], 32'h12345678);

      req(1'b1, 1'b0, 32'h0000_0008, 32'hA5A5A5A5, 1'b0, 1'b0);
      req(1'b0, 1'b0, 32'h0000_100B, 32'h0, 1'b0, 1'b0);
      check("alias_rd", rd_a[sel], 32'hA5A5A5A5);

      req(1'b1, 1'b0, 32'h20, 32'h1, 1'b0, 1'b0);
      req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
      req(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check("flush_rd_kept", rd_a[sel], 32'h1);
      req(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
      check("flush_store_kept", rd_a[sel], 32'h1);

      req(1'b1, 1'b0, 32'h30, 32'h3030_3030, 1'b0, 1'b0);
      req(1'b1, 1'b0, 32'h40, 32'h4040_4040, 1'b0, 1'b0);
      req(1'b0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0);
      check("unstable_rd", rd_a[sel], 32'h3030_3030);

      for (int i = 0; i < 4; i++) begin
        d = $urandom;
        req(1'b1, 1'b0, 32'h50, d, 1'b0, 1'b1);
        req(1'b0, 1'b0, 32'h50, 32'h0, 1'b0, 1'b1);
        check("b2b_rd", rd_a[sel], d);
      end
      valid = 1'b0;

      req(1'b1, 1'b0, 32'h14, 32'h0BAD_F00D, 1'b0, 1'b0);
      reset_mid_write();
      req(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
        a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 31)) << 2);
        req(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), a, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      valid = 1'b0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the Processor's data port (`cache_addr_data`, `cache_wr_data`, `cache_rw_data`, `cache_valid_data`, `cache_flush_data` / `cache_rd_data`, `cache_ready_data`). It is the responding end of the request/ready handshake the Processor initiates, backed by a word-addressed on-chip store. The responder has a configurable response latency, so the Processor's stall logic can be exercised against a non-trivial `cache_ready_data`. It sits beside `I_cache` in the top level, clocked from `CLK0_OUT`.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width. The store holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: edges from acceptance to the `cache_ready_data` assertion. Legal range is 1..15.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `cache_addr_data`  in  32  byte address. Bits [ADDR_W+1:2] select the word.
- `cache_wr_data`  in  32  write data.
- `cache_rw_data`  in  1  request type: 1 = write, 0 = read.
- `cache_valid_data`  in  1  request present.
- `cache_flush_data`  in  1  flush request, qualified by `cache_valid_data`.
- `cache_rd_data`  out  32  read data, registered.
- `cache_ready_data`  out  1  one-cycle completion pulse, registered.

## Operation
- States and transitions:
  - IDLE: if `cache_valid_data`=1, capture addr, wdata, rw and flush; load the counter with LATENCY-1; go to BUSY. Otherwise stay in IDLE.
  - BUSY: if counter=0, perform the operation and go to RESP. Otherwise decrement the counter.
  - RESP: `cache_ready_data`=1 for exactly this cycle. Unconditionally go to IDLE.
- Requests are accepted only in IDLE.
  - Inputs are sampled only at the accept edge. Later changes to addr, wdata, rw, flush or valid do not affect the in-flight request.
  - If valid is dropped while the block is in BUSY, the request still completes and `cache_ready_data` still pulses.
- Operations are performed at the BUSY→RESP edge:
  - Read: `cache_rd_data` ← mem[addr[ADDR_W+1:2]].
  - Write: mem[word] ← wdata. `cache_rd_data` also ← wdata (write-through echo).
  - Flush (flush=1 overrides rw): the store is unchanged and `cache_rd_data` holds its previous value. Only the ready pulse is produced.
- `cache_rd_data` holds its value from RESP until the next read or write completes.
- Address rules:
  - addr[1:0] are ignored, so there are no misalignment errors.
  - Bits above ADDR_W+1 are ignored, so addresses alias modulo 2^(ADDR_W+2).
- A read-after-write to the same word returns the new data, because operations are serialised.
- Back-to-back requests: the Processor deasserts valid, or presents the next request, in the cycle after `cache_ready_data`. A valid held high through RESP is treated as a new request at the next IDLE edge.
- Reset (asynchronous, at any time): state → IDLE, counter → 0, `cache_ready_data` → 0, `cache_rd_data` → 0.
  - An in-flight write that has not reached the BUSY→RESP edge is discarded.
  - Store contents are not cleared by reset.

## Timing
- Reset values: `cache_ready_data`=0 and `cache_rd_data`=32'h0, asserted immediately on RST, not at a clock edge.
- Latency, with edge 0 as the accept edge:
  - State is BUSY after edge 0.
  - `cache_ready_data` is high from edge LATENCY to edge LATENCY+1.
  - State returns to IDLE at edge LATENCY+1.
  - Earliest next accept is edge LATENCY+2, so throughput is one request per LATENCY+2 cycles.
- LATENCY=1: accept at edge 0, ready high during cycle 1, IDLE at edge 2.
- `cache_rd_data` is valid in the same cycle that `cache_ready_data` is high.
- No combinational path runs from any input to any output.
- RST deasserted synchronously to CLK by the top level. A request is first accepted at the first rising edge with RST=0.

## Test plan
- Reset mid-request:
  - Stimulus: LATENCY=4. Write 32'hDEADBEEF to 0x10, assert RST for 1 cycle during BUSY, then read 0x10.
  - Required response: ready is 0 during reset, `cache_rd_data` is 0 immediately, and the read returns the pre-write value.
- Latency sweep:
  - Stimulus: for LATENCY=1, 2 and 15, write 32'h12345678 to 0x04, then read 0x04.
  - Required response: ready rises exactly LATENCY edges after each accept, the read returns 32'h12345678, and `cache_ready_data` is high for exactly 1 cycle.
- Aliasing and alignment:
  - Stimulus: ADDR_W=10. Write 32'hA5A5A5A5 to 0x0000_0008, then read 0x0000_100B.
  - Required response: the read returns 32'hA5A5A5A5.
- Flush:
  - Stimulus: read 0x20 (=32'h1), then flush with rw=1 and wdata=32'hFFFF_FFFF at 0x20, then read 0x20.
  - Required response: the flush ready pulse occurs, `cache_rd_data` stays 32'h1 through the flush, and the read returns 32'h1.
- Input instability:
  - Stimulus: after accepting a read of 0x30, change addr to 0x40 and drop valid during BUSY.
  - Required response: the response is mem[0x30] and is still delivered.
- Back-to-back:
  - Stimulus: hold valid high continuously, alternating write and read on the same word.
  - Required response: requests are accepted at edges 0, L+2, 2L+4, …, and each read returns the preceding write's data.
